// File: rtl/upcounter_sequencer_pkg.sv
// ============================================================================
//  upcounter_sequencer_pkg
//  Shared state encoding and default widths for the counter sequencer.
//  Rev 1.0
// ============================================================================
`default_nettype none

package upcounter_sequencer_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_PERW  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_PAUSE = 2'd3
  } seq_state_e;

endpackage : upcounter_sequencer_pkg

`default_nettype wire

// File: rtl/syn_upcounter_en.sv
// ============================================================================
//  syn_upcounter_en
//  WIDTH-bit synchronous up-counter with synchronous clear and count enable.
//  Rev 1.0
// ============================================================================
`default_nettype none

module syn_upcounter_en
  import upcounter_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count = count_q;

endmodule : syn_upcounter_en

`default_nettype wire

// File: rtl/upcounter_sequencer.sv
// ============================================================================
//  upcounter_sequencer
//  Drives clear/enable of an external up-counter, pulses done at the latched
//  terminal count, one-shot or auto-reload, and counts completed periods.
//  Rev 1.0
// ============================================================================
`default_nettype none

module upcounter_sequencer
  import upcounter_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int PERW  = DEF_PERW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] terminal,
  input  logic [WIDTH-1:0] count_in,
  output logic             cnt_clr,
  output logic             cnt_en,
  output logic             busy,
  output logic             done,
  output logic [PERW-1:0]  periods
);

  seq_state_e       state_q, state_d;
  logic [WIDTH-1:0] term_q, term_d;
  logic             reload_q, reload_d;
  logic [PERW-1:0]  periods_q, periods_d;
  logic             busy_q;

  logic hit;
  logic abort_now;

  assign hit       = (count_in == term_q);
  assign abort_now = abort && (state_q != ST_IDLE);

  always_comb begin
    state_d   = state_q;
    term_d    = term_q;
    reload_d  = reload_q;
    periods_d = periods_q;
    if (abort_now) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !abort) begin
            state_d   = ST_CLEAR;
            term_d    = terminal;
            reload_d  = auto_reload;
            periods_d = '0;
          end
        end
        ST_CLEAR: state_d = ST_RUN;
        ST_RUN: begin
          // A terminal hit wins over a simultaneous pause request.
          if (hit) begin
            periods_d = periods_q + PERW'(1);
            if (!reload_q) state_d = ST_IDLE;
          end else if (pause) begin
            state_d = ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (!pause) state_d = ST_RUN;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      term_q    <= '0;
      reload_q  <= 1'b0;
      periods_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      term_q    <= term_d;
      reload_q  <= reload_d;
      periods_q <= periods_d;
      busy_q    <= (state_d != ST_IDLE);
    end
  end

  // Reset and abort both force a counter clear so the datapath restarts at 0.
  always_comb begin
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_CLEAR: cnt_clr = 1'b1;
      ST_RUN: begin
        if (hit) begin
          done    = 1'b1;
          cnt_clr = reload_q;
        end else begin
          cnt_en = !pause;
        end
      end
      default: ;
    endcase
    if (abort_now || reset) begin
      cnt_clr = 1'b1;
      cnt_en  = 1'b0;
      done    = 1'b0;
    end
  end

  assign busy    = busy_q;
  assign periods = periods_q;

endmodule : upcounter_sequencer

`default_nettype wire

// File: tb/tb_upcounter_sequencer.sv
// Self-checking bench: sequencer plus counter against a behavioural model.
`default_nettype none

module tb_upcounter_sequencer;

  localparam int W = 4;
  localparam int P = 8;

  logic         clk = 1'b0;
  logic         reset, start, pause, abort, auto_reload;
  logic [W-1:0] terminal;
  logic [W-1:0] count_in;
  logic         cnt_clr, cnt_en, busy, done;
  logic [P-1:0] periods;

  always #5 clk = ~clk;

  syn_upcounter_en #(.WIDTH(W)) u_cnt (
    .clk   (clk),
    .reset (cnt_clr),
    .en    (cnt_en),
    .count (count_in)
  );

  upcounter_sequencer #(.WIDTH(W), .PERW(P)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .pause       (pause),
    .abort       (abort),
    .auto_reload (auto_reload),
    .terminal    (terminal),
    .count_in    (count_in),
    .cnt_clr     (cnt_clr),
    .cnt_en      (cnt_en),
    .busy        (busy),
    .done        (done),
    .periods     (periods)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: run phase, counter value, latched settings, period tally.
  localparam int M_IDLE = 0, M_CLR = 1, M_RUN = 2, M_HOLD = 3;
  int m_ph    = M_IDLE;
  int m_cnt   = 0;
  int m_term  = 0;
  bit m_rel   = 1'b0;
  int m_per   = 0;
  bit m_known = 1'b0;
  bit obs_done;

  task automatic step(input bit r, input bit s, input bit p, input bit a,
                      input bit ar, input int t);
    bit hit, live;
    int e_clr, e_en, e_done, e_busy;
    reset = r; start = s; pause = p; abort = a; auto_reload = ar;
    terminal = t[W-1:0];
    @(negedge clk);
    hit    = (m_cnt == m_term);
    live   = (m_ph != M_IDLE);
    e_busy = int'(live);
    e_clr  = 0; e_en = 0; e_done = 0;
    if (m_ph == M_CLR) e_clr = 1;
    if (m_ph == M_RUN) begin
      if (hit) begin e_done = 1; e_clr = int'(m_rel); end
      else e_en = int'(!p);
    end
    if ((a && live) || r) begin e_clr = 1; e_en = 0; e_done = 0; end
    check("clr", 32'(cnt_clr), e_clr);
    check("en", 32'(cnt_en), e_en);
    if (m_known) begin
      check("count", 32'(count_in), m_cnt);
      check("busy", 32'(busy), e_busy);
      check("done", 32'(done), e_done);
      check("periods", 32'(periods), m_per);
      check("en_and_clr", 32'(cnt_en & cnt_clr), 0);
    end
    obs_done = done;
    if (e_clr == 1) m_cnt = 0;
    else if (e_en == 1) m_cnt = (m_cnt + 1) % 16;
    if (r) begin
      m_ph = M_IDLE; m_term = 0; m_rel = 1'b0; m_per = 0; m_known = 1'b1;
    end else if (a && live) begin
      m_ph = M_IDLE;
    end else begin
      case (m_ph)
        M_IDLE: if (s && !a) begin m_ph = M_CLR; m_term = t; m_rel = ar; m_per = 0; end
        M_CLR:  m_ph = M_RUN;
        M_RUN: begin
          if (hit) begin
            m_per = (m_per + 1) % 256;
            if (!m_rel) m_ph = M_IDLE;
          end else if (p) m_ph = M_HOLD;
        end
        default: if (!p) m_ph = M_RUN;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  // Start at cycle 0, then n cycles with scheduled pause/start/abort/reset.
  // Terminal and mode inputs are scrambled after the start to show latching.
  task automatic run_seq(input bit ar, input int t, input int n,
                         input int p_from, input int p_to, input int st_at,
                         input int ab_at, input int rs_at,
                         output int first, output int second, output int nd);
    first = -1; second = -1; nd = 0;
    step(1'b0, 1'b1, 1'b0, 1'b0, ar, t);
    for (int i = 1; i <= n; i++) begin
      step(i == rs_at, i == st_at, (i >= p_from) && (i <= p_to), i == ab_at,
           !ar, (t ^ 10) & 15);
      if (obs_done) begin
        nd++;
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
  endtask

  int f, s2, nd;

  initial begin
    reset = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0;
    auto_reload = 1'b0; terminal = '0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 7);
    check("rst_busy", 32'(busy), 0);
    check("rst_periods", 32'(periods), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3);

    // One-shot T=5: done T+2 cycles after the start edge.
    run_seq(1'b0, 5, 12, 0, 0, 0, 0, 0, f, s2, nd);
    check("os5_latency", f, 7);
    check("os5_pulses", nd, 1);
    check("os5_periods", 32'(periods), 1);

    // Auto-reload T=3: period T+1, four pulses by cycle 17.
    run_seq(1'b1, 3, 17, 0, 0, 0, 0, 0, f, s2, nd);
    check("ar3_first", f, 5);
    check("ar3_period", s2 - f, 4);
    check("ar3_periods", 32'(periods), 4);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    check("ar3_abort_idle", 32'(busy), 0);

    // Pause high two cycles: three frozen cycles (RUN with en low + 2 PAUSE).
    run_seq(1'b0, 5, 14, 3, 4, 0, 0, 0, f, s2, nd);
    check("pause_latency", f, 10);

    // Pause raised on the hit cycle does not block done.
    run_seq(1'b0, 2, 8, 4, 4, 0, 0, 0, f, s2, nd);
    check("pause_hit_latency", f, 4);

    run_seq(1'b0, 0, 5, 0, 0, 0, 0, 0, f, s2, nd);
    check("t0_os_latency", f, 2);
    check("t0_os_pulses", nd, 1);

    run_seq(1'b1, 0, 6, 0, 0, 0, 0, 0, f, s2, nd);
    check("t0_ar_first", f, 2);
    check("t0_ar_pulses", nd, 5);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);

    // Abort at count 2 with a start request during RUN just before it.
    run_seq(1'b0, 9, 10, 0, 0, 3, 4, 0, f, s2, nd);
    check("abort_pulses", nd, 0);
    check("abort_busy", 32'(busy), 0);

    // Reset mid-run at count 4, then a fresh start behaves normally.
    run_seq(1'b0, 9, 8, 0, 0, 0, 0, 6, f, s2, nd);
    check("rst_mid_pulses", nd, 0);
    check("rst_mid_periods", 32'(periods), 0);
    run_seq(1'b0, 5, 9, 0, 0, 0, 0, 0, f, s2, nd);
    check("after_rst_latency", f, 7);

    // Periods wrap: 259 pulses of an auto-reload T=0 run leave 259 mod 256.
    run_seq(1'b1, 0, 260, 0, 0, 0, 0, 0, f, s2, nd);
    check("wrap_pulses", nd, 259);
    check("wrap_periods", 32'(periods), 3);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);

    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(199) == 0, $urandom_range(7) == 0,
           $urandom_range(5) == 0, $urandom_range(39) == 0,
           1'($urandom_range(1)), int'($urandom_range(15)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_upcounter_sequencer

`default_nettype wire

// File: doc/upcounter_sequencer.md
Name: upcounter_sequencer

Overview:
- Controller that sequences a synchronous up-counter datapath with a clear and an enable input.
- Accepts start/pause/abort commands and latches a programmable terminal count; then drives clear/enable to the counter and watches its count output.
- Pulses done at terminal count; runs one-shot or auto-reload.
- Sits between control logic and a WIDTH-bit counter (enable variant of the 4-bit synchronous up-counter).

Parameters:
- WIDTH, 4, counter width; also width of terminal and count_in.
- PERW, 8, width of the completed-period counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a run; sampled only in IDLE.
- pause  in  1  level; while high in RUN/PAUSE, counting is held.
- abort  in  1  terminate any run; return to IDLE.
- auto_reload  in  1  mode; 1 = restart at terminal, 0 = one-shot. Latched with terminal on start.
- terminal  in  WIDTH  terminal count value; latched on accepted start.
- count_in  in  WIDTH  registered count output of the counter.
- cnt_clr  out  1  counter synchronous clear.
- cnt_en  out  1  counter increment enable.
- busy  out  1  high in CLEAR, RUN, PAUSE.
- done  out  1  one-cycle pulse when count_in equals the latched terminal in RUN.
- periods  out  PERW  number of completed periods since the last start; wraps.

Behaviour:
- Reset (synchronous, active-high; one clock; port names clk/reset):
  - state = IDLE.
  - cnt_clr=1 during the reset cycle; afterwards cnt_clr=0 in IDLE.
  - cnt_en=0, busy=0, done=0, periods=0.
  - term_q=0, reload_q=0.
- States: IDLE, CLEAR, RUN, PAUSE. Outputs are Moore except done and cnt_clr in RUN, which are combinational on count_in==term_q.
- IDLE:
  - cnt_en=0.
  - On start=1 (and abort=0): latch term_q<=terminal, reload_q<=auto_reload, periods<=0; next state CLEAR.
- CLEAR: cnt_clr=1, cnt_en=0, busy=1; next state RUN unconditionally. The counter reads 0 on the first RUN cycle.
- RUN, count_in != term_q:
  - cnt_en = ~pause.
  - If pause=1, next state PAUSE.
- RUN, count_in == term_q (terminal hit):
  - done=1, cnt_en=0, periods+1.
  - reload_q=1: cnt_clr=1 this cycle; stay in RUN.
  - reload_q=0: next state IDLE.
  - Terminal hit takes priority over pause.
- PAUSE:
  - cnt_en=0, busy=1; hold until pause=0, then next state RUN.
  - No done in PAUSE, even if count_in==term_q; it is evaluated on return to RUN.
- Timing:
  - Start accepted at edge k: CLEAR during cycle k+1; first enabled RUN cycle k+2.
  - One-shot, no pause, terminal T: done is asserted T+2 cycles after the start edge.
  - Auto-reload period = T+1 cycles between done pulses.
- terminal=0: first RUN cycle is already the hit.
  - One-shot: done at cycle k+2, then IDLE.
  - Auto-reload: done every cycle.
- abort=1 (any non-IDLE state, highest priority):
  - Next state IDLE; cnt_clr=1 and cnt_en=0 that cycle; done suppressed.
  - periods holds its value.
- Ignored inputs:
  - start while busy.
  - pause, abort, start in IDLE other than the start acceptance above.
  - terminal and auto_reload changes mid-run; only the latched values are used.
- periods wraps 2^PERW-1 -> 0.
- Reset mid-run behaves exactly as the reset values above, from the next edge.
- Never assert cnt_en and cnt_clr together.

Decomposition:
- Shared package:
  - State enum (IDLE, CLEAR, RUN, PAUSE; 2 bits).
  - Default WIDTH/PERW constants.
- Sub-module `syn_upcounter_en`: counter with clk, reset (clear), en, count; WIDTH parameter. Instantiated by the bench and top level, not inside the sequencer.

Test Plan:
- One-shot, terminal=5, start pulse at cycle 0:
  - Cycle 1: cnt_clr=1.
  - Cycles 2–6: cnt_en=1, count_in 0..4.
  - Cycle 7: done=1 with count_in=5.
  - Cycle 8: IDLE, busy=0, periods=1.
- Auto-reload, terminal=3: done pulses every 4 cycles; count_in sequence 0,1,2,3,0,...; periods=4 after 4 pulses; never cnt_en&cnt_clr.
- Pause for 3 cycles mid-run, terminal=5:
  - count_in frozen; cnt_en=0; PAUSE.
  - done delayed by exactly 3 cycles vs the unpaused run.
  - pause asserted on the hit cycle: done still fires.
- terminal=0 edge:
  - One-shot: done at cycle 2, then IDLE.
  - Auto-reload: done every cycle from cycle 2.
- Abort at count_in=2, terminal=9: next cycle IDLE, cnt_clr=1 that cycle, no done, periods unchanged; start during RUN ignored.
- reset=1 during RUN with count_in=4: next cycle all outputs at reset values, state IDLE; new start works normally.
